sdu_uart_rx: RTL
================

// Module: sdu_uart_rx
// PURPOSE
//  Serial receive front end for the debug unit. Sits between the board rxd pin and the SDU
//  command parser. Synchronises rxd, recovers 8N1 frames by 16x oversampling, and presents
//  each byte on a valid/ready port with a one-byte holding register.
//  Reports framing and overrun errors so the parser can resync its command stream.
// PARAMETERS
//  CLK_FREQ   100_000_000  input clock frequency, Hz
//  BAUD       115200       line rate, bit/s
//  OVS        16           oversample ticks per bit; fixed at 16, other values unsupported
// PORTS
//  clk        in   1  system clock, same domain as the SDU
//  rst        in   1  synchronous reset, active-high
//  rxd        in   1  asynchronous serial input, idle high
//  dout       out  8  received byte, LSB = first data bit on the line
//  dout_vld   out  1  dout holds an unconsumed byte
//  dout_rdy   in   1  consumer accepts dout when dout_vld && dout_rdy on a rising clk edge
//  frame_err  out  1  one-cycle pulse: stop bit (or parity) sampled bad
//  overrun    out  1  sticky: a byte completed while the holding register was full
//  ovr_clr    in   1  clears overrun; wins over a simultaneous set
//  busy       out  1  FSM is not in IDLE
// BEHAVIOUR
//  - Sync: rxd passes through 2 flops (reset value 1) before any use. Edge detection uses the
//    synchronised value only.
//  - Tick: DIV = CLK_FREQ/(BAUD*16), rounded to nearest and minimum 1. A counter 0..DIV-1 pulses
//    tick on wrap. The counter is held at 0 in IDLE and starts on the start edge.
//  - FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE, plus WAIT_HI.
//    IDLE:    falling edge on synced rxd -> START, with tick count=0.
//    START:   on the 8th tick, sample the line. 0 -> DATA with bit index 0. 1 -> IDLE (glitch
//             rejected, no error reported).
//    DATA:    sample every 16 ticks after the start mid-point and shift in LSB first.
//             After bit 7 -> PARITY if compiled in, otherwise STOP.
//    STOP:    sample 16 ticks later. 1 -> deliver the byte. 0 -> frame_err pulse, drop the byte,
//             -> WAIT_HI.
//    WAIT_HI: remain until synced rxd = 1, then go to IDLE. Breaks never generate further bytes.
//  - Delivery: the cycle after a good stop sample, the byte is loaded into dout and dout_vld=1.
//    dout_vld stays set until a handshake occurs.
//    If dout_vld && !dout_rdy at delivery: the new byte is dropped, dout is unchanged, overrun=1.
//    Handshake and delivery in the same cycle: the new byte is loaded, dout_vld stays 1,
//    no overrun.
//  - FSM returns to IDLE at the stop mid-point, so back-to-back frames with a 1-bit stop are
//    received.
//  - Reset: dout=0, dout_vld=0, frame_err=0, overrun=0, busy=0, FSM=IDLE, sync flops=1, counters=0.
//    Reset mid-frame abandons the partial byte. Bits still on the line do not form a false byte
//    unless a new falling edge occurs.
//  - dout is stable while dout_vld=1. dout_rdy is ignored while dout_vld=0.
// CONFIGURATION
//  SDU_UART_PARITY_EN defined: a PARITY state follows bit 7 and samples 16 ticks later
//    (even parity). A mismatch pulses frame_err, drops the byte, and proceeds to STOP normally,
//    without WAIT_HI unless the stop bit is also bad.
//  Undefined: 8N1 only. The bit after bit 7 is treated as stop.
// TESTING  (CLK_FREQ=1_600_000, BAUD=100_000 -> DIV=1, 16 clk/bit)
//  1. Send 0xA5, dout_rdy=1 -> dout=0xA5, dout_vld high for exactly 1 cycle, about 152 clk after
//     the start edge, no errors.
//  2. 4-clk low glitch on idle rxd -> no dout_vld, no frame_err, busy returns to 0 by clk 10.
//  3. Send 0x3C with stop bit forced 0, then hold rxd low for 40 clk -> one frame_err pulse,
//     no dout_vld, busy=1 until rxd=1.
//  4. dout_rdy=0, send 0x11 then 0x22 -> dout=0x11 held, overrun=1. Pulse ovr_clr -> overrun=0.
//     Handshake yields 0x11.
//  5. Back-to-back 0x00, 0xFF, 0x55 with 1 stop bit, dout_rdy=1 -> three bytes in order,
//     no errors.
//  6. Assert rst at data bit 4 of 0x81, then release -> all outputs at reset values, no byte
//     delivered. Next frame 0x81 received correctly.
//     With SDU_UART_PARITY_EN: 0x07 sent with wrong parity -> frame_err, no byte.

Source files
------------

// File: rtl/sdu_uart_rx.sv
// 8N1 UART receiver with 16x oversampling and a one-byte valid/ready holding register.
// Optional even-parity frame check when SDU_UART_PARITY_EN is defined.
module sdu_uart_rx #(
    parameter int CLK_FREQ = 100_000_000,
    parameter int BAUD     = 115200,
    parameter int OVS      = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] dout,
    output logic       dout_vld,
    input  logic       dout_rdy,
    output logic       frame_err,
    output logic       overrun,
    input  logic       ovr_clr,
    output logic       busy
);

    localparam int DIV_RAW = (CLK_FREQ + (BAUD * OVS) / 2) / (BAUD * OVS);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [3:0] OS_MID = 4'(OVS / 2 - 1);
    localparam logic [3:0] OS_BIT = 4'(OVS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HI
    } state_t;

    state_t           state, state_n;
    logic [1:0]       sync;
    logic             rxd_q;
    logic [2:0]       vld_pipe;
    logic             rxd_s, fall;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       os_cnt, os_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             deliver, ferr_set;
`ifdef SDU_UART_PARITY_EN
    logic             par_bad, par_bad_n;
`endif

    // vld_pipe marks which history flops hold real line samples since reset, so the
    // reset value of 1 can never masquerade as the high side of a start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync     <= 2'b11;
            rxd_q    <= 1'b1;
            vld_pipe <= '0;
        end else begin
            sync     <= {sync[0], rxd};
            rxd_q    <= sync[1];
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign rxd_s = sync[1];
    assign fall  = vld_pipe[2] & rxd_q & ~rxd_s;

    always_ff @(posedge clk) begin
        if (rst || state == S_IDLE)
            div_cnt <= '0;
        else if (div_cnt == DIV_MAX)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (state != S_IDLE) && (div_cnt == DIV_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            os_cnt  <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef SDU_UART_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            os_cnt  <= os_cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
`ifdef SDU_UART_PARITY_EN
            par_bad <= par_bad_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        os_cnt_n  = os_cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        deliver   = 1'b0;
        ferr_set  = 1'b0;
`ifdef SDU_UART_PARITY_EN
        par_bad_n = par_bad;
`endif
        if (tick)
            os_cnt_n = os_cnt + 4'd1;
        case (state)
            S_IDLE: begin
                os_cnt_n = '0;
                if (fall)
                    state_n = S_START;
            end
            S_START: begin
                if (tick && os_cnt == OS_MID) begin
                    os_cnt_n  = '0;
                    bit_idx_n = '0;
`ifdef SDU_UART_PARITY_EN
                    par_bad_n = 1'b0;
`endif
                    state_n   = rxd_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (tick && os_cnt == OS_BIT) begin
                    os_cnt_n  = '0;
                    shreg_n   = {rxd_s, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef SDU_UART_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef SDU_UART_PARITY_EN
            S_PARITY: begin
                if (tick && os_cnt == OS_BIT) begin
                    os_cnt_n = '0;
                    state_n  = S_STOP;
                    if (^{shreg, rxd_s}) begin
                        ferr_set  = 1'b1;
                        par_bad_n = 1'b1;
                    end
                end
            end
`endif
            S_STOP: begin
                // Leave at the stop mid-point so a following start edge is not missed.
                if (tick && os_cnt == OS_BIT) begin
                    os_cnt_n = '0;
                    if (rxd_s) begin
                        state_n = S_IDLE;
`ifdef SDU_UART_PARITY_EN
                        deliver = !par_bad;
`else
                        deliver = 1'b1;
`endif
                    end else begin
                        ferr_set = 1'b1;
                        state_n  = S_WAIT_HI;
                    end
                end
            end
            S_WAIT_HI: begin
                os_cnt_n = '0;
                if (rxd_s)
                    state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A byte arriving while the holding register is still owned by the consumer is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout      <= '0;
            dout_vld  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr_set;
            if (deliver && (!dout_vld || dout_rdy)) begin
                dout     <= shreg;
                dout_vld <= 1'b1;
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
            if (ovr_clr)
                overrun <= 1'b0;
            else if (deliver && dout_vld && !dout_rdy)
                overrun <= 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
